serial_cmp_ctrl: RTL
====================

Name: serial_cmp_ctrl

Overview:
Sequencer that performs an N-bit magnitude comparison by stepping a single 1-bit comparator slice over two captured operands, MSB first. It accepts a start request, scans bit by bit, stops at the first differing bit (or at the LSB), and reports registered gt/eq/lt flags with a one-cycle done pulse. It sits between a requesting controller and the 1-bit compare datapath, so one comparator cell serves arbitrary operand widths.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..64.
EARLY_EXIT, 1, 1 = stop at the first differing bit; 0 = always scan all WIDTH bits, result taken from the first (most significant) difference.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a_in  input  WIDTH  operand A; captured on the accepted start edge only
b_in  input  WIDTH  operand B; captured on the accepted start edge only
busy  output  1  high in SCAN and DONE
done  output  1  one-cycle pulse; result valid
gt  output  1  A > B
eq  output  1  A == B
lt  output  1  A < B

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, gt, eq, lt = 0; operand regs, bit index and first-difference flag cleared. Reset asserted mid-scan aborts immediately. No result is produced.
- States: IDLE, SCAN, DONE.
- IDLE: start=1 at an edge -> capture a_in/b_in, idx=WIDTH-1, clear gt/eq/lt, go SCAN.
- SCAN: each cycle presents a_reg[idx], b_reg[idx] to the slice (h/e/l).
  - EARLY_EXIT=1:
    - h=1 -> gt=1, go DONE.
    - l=1 -> lt=1, go DONE.
    - e=1 and idx==0 -> eq=1, go DONE.
    - e=1 otherwise -> idx-1.
  - EARLY_EXIT=0:
    - On the first h or l, latch gt/lt and set the diff-seen flag. Later bits are ignored.
    - At idx==0, go DONE. Set eq=1 iff no difference was seen.
- DONE: done=1 for exactly this one cycle, then go IDLE. busy drops to 0 on the same edge.
- Latency: let S = bits scanned. S = (WIDTH - index of the MSB-most differing bit) with EARLY_EXIT=1 and a difference present; otherwise S = WIDTH. Results update and DONE is entered on the S-th edge after the start edge. done is high for cycle S+1 only. The next start is accepted at the edge ending the DONE cycle + 1, i.e. once back in IDLE.
- gt/eq/lt are mutually exclusive. They hold their value after done until the next accepted start, which clears them.
- start while busy (SCAN or DONE) is ignored. No queuing.
- a_in/b_in changes after capture have no effect on the running comparison.
- idx width is clog2(WIDTH). idx never underflows; the transition out of SCAN occurs at idx==0.
- All outputs are registered. No combinational path from start/a_in/b_in to any output.

Decomposition:
- Package serial_cmp_pkg:
  - state enum {IDLE, SCAN, DONE}
  - result encoding constants (RES_GT, RES_EQ, RES_LT) for the bench scoreboard
  - function idx_width(WIDTH)
- Sub-module cmp_bit1: purely combinational 1-bit slice; inputs a, b; outputs h = a&~b, e = ~(a^b), l = ~a&b. Instantiated once.
- Controller FSM, operand registers and index counter live in serial_cmp_ctrl.

Test Plan:
1. WIDTH=8, EARLY_EXIT=1, start with a_in=8'h80, b_in=8'h00 -> gt=1, eq=0, lt=0; done pulses on cycle 2 after the start edge; busy high for 2 cycles.
2. WIDTH=8, a_in=8'h5A, b_in=8'h5A -> eq=1 after 8 scan cycles; done high for exactly one cycle; flags hold until the next start.
3. WIDTH=8, a_in=8'h12, b_in=8'h13 -> lt=1 at S=8. Repeat with EARLY_EXIT=0 and a_in=8'hF0, b_in=8'h70 -> gt=1, S=8, result from bit 7 not bit 6.
4. start held high continuously; operands changed mid-scan -> second request accepted only after DONE returns to IDLE; first result reflects the captured operands.
5. rst_n pulled low during SCAN of a_in=8'hFF, b_in=8'h00 under EARLY_EXIT=0 -> all outputs 0 immediately, no done; new start after release completes normally.
6. Exhaustive WIDTH=2 sweep, all 16 operand pairs -> exactly one of gt/eq/lt matches the integer compare; S matches the latency rule for each pair.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the bit-serial magnitude comparator.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Result encodings as {gt, eq, lt}.
    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

    function automatic int idx_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_cmp_ctrl_bit1.sv
// Single-bit compare slice: a greater, equal, or less than b.
module cmp_bit1 (
    input  logic a,
    input  logic b,
    output logic h,
    output logic e,
    output logic l
);

    assign h = a & ~b;
    assign e = ~(a ^ b);
    assign l = ~a & b;

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Sequencer that compares two captured operands MSB first through one 1-bit
// compare slice, reporting registered gt/eq/lt with a one-cycle done pulse.
module serial_cmp_ctrl
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int             IW      = idx_width(WIDTH);
    localparam logic [IW-1:0]  IDX_MSB = IW'(WIDTH - 1);

    state_e           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IW-1:0]    idx;
    logic             diff_seen;
    logic             bit_h;
    logic             bit_e;
    logic             bit_l;

    cmp_bit1 u_slice (
        .a (a_reg[idx]),
        .b (b_reg[idx]),
        .h (bit_h),
        .e (bit_e),
        .l (bit_l)
    );

    // NOTE: every register here uses <= so all updates in a cycle see the
    // pre-edge values; blocking = would make the order of statements matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            idx       <= '0;
            diff_seen <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            gt        <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a_in;
                        b_reg     <= b_in;
                        idx       <= IDX_MSB;
                        diff_seen <= 1'b0;
                        gt        <= 1'b0;
                        eq        <= 1'b0;
                        lt        <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (EARLY_EXIT) begin
                        if (bit_h) begin
                            gt    <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (bit_l) begin
                            lt    <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (idx == '0) begin
                            eq    <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end else begin
                        // Only the most significant difference decides the result.
                        if (!diff_seen && (bit_h || bit_l)) begin
                            gt        <= bit_h;
                            lt        <= bit_l;
                            diff_seen <= 1'b1;
                        end
                        if (idx == '0) begin
                            eq    <= ~diff_seen & bit_e;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
